// File: rtl/sram_axi_bridge.sv
// rtl/sram_axi_bridge.sv - sram-like inst/data ports to single AXI3 master bridge
//
// Purpose: merges the core's instruction (read-only) and data sram-like ports
// into one AXI3 master. Up to two reads in flight (inst ID 0, data ID 1) plus
// one write. Data reads wait for any write to fully complete.
//
// Ports:
//   clk, resetn                 clock, synchronous active-low reset
//   inst_sram_* / data_sram_*   sram-like request/response ports
//   ar* / r*                    AXI read address / read data channels
//   aw* / w* / b*               AXI write address / write data / response channels

module sram_axi_bridge #(
    parameter int ID_W = 4
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            inst_sram_req,
    input  logic            inst_sram_wr,
    input  logic [1:0]      inst_sram_size,
    input  logic [3:0]      inst_sram_wstrb,
    input  logic [31:0]     inst_sram_addr,
    input  logic [31:0]     inst_sram_wdata,
    output logic            inst_sram_addr_ok,
    output logic            inst_sram_data_ok,
    output logic [31:0]     inst_sram_rdata,
    input  logic            data_sram_req,
    input  logic            data_sram_wr,
    input  logic [1:0]      data_sram_size,
    input  logic [3:0]      data_sram_wstrb,
    input  logic [31:0]     data_sram_addr,
    input  logic [31:0]     data_sram_wdata,
    output logic            data_sram_addr_ok,
    output logic            data_sram_data_ok,
    output logic [31:0]     data_sram_rdata,
    output logic [ID_W-1:0] arid,
    output logic [31:0]     araddr,
    output logic [7:0]      arlen,
    output logic [2:0]      arsize,
    output logic [1:0]      arburst,
    output logic [1:0]      arlock,
    output logic [3:0]      arcache,
    output logic [2:0]      arprot,
    output logic            arvalid,
    input  logic            arready,
    input  logic [ID_W-1:0] rid,
    input  logic [31:0]     rdata,
    input  logic [1:0]      rresp,
    input  logic            rlast,
    input  logic            rvalid,
    output logic            rready,
    output logic [ID_W-1:0] awid,
    output logic [31:0]     awaddr,
    output logic [7:0]      awlen,
    output logic [2:0]      awsize,
    output logic [1:0]      awburst,
    output logic [1:0]      awlock,
    output logic [3:0]      awcache,
    output logic [2:0]      awprot,
    output logic            awvalid,
    input  logic            awready,
    output logic [ID_W-1:0] wid,
    output logic [31:0]     wdata,
    output logic [3:0]      wstrb,
    output logic            wlast,
    output logic            wvalid,
    input  logic            wready,
    input  logic [ID_W-1:0] bid,
    input  logic [1:0]      bresp,
    input  logic            bvalid,
    output logic            bready
);
    localparam logic [ID_W-1:0] INST_ID = ID_W'(0);
    localparam logic [ID_W-1:0] DATA_ID = ID_W'(1);

    typedef enum logic {AR_IDLE, AR_SEND} ar_state_e;
    typedef enum logic [1:0] {W_IDLE, W_SEND, W_RESP} w_state_e;

    ar_state_e   ar_state_q, ar_state_d;
    logic        ar_data_q, ar_data_d;      // 1: AR in progress belongs to data port
    logic [31:0] araddr_q, araddr_d;
    logic [1:0]  arsize_q, arsize_d;
    logic        inst_out_q, inst_out_d;
    logic        data_out_q, data_out_d;
    w_state_e    w_state_q, w_state_d;
    logic        awvalid_q, awvalid_d;
    logic        wvalid_q, wvalid_d;
    logic [31:0] awaddr_q, awaddr_d;
    logic [1:0]  awsize_q, awsize_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic        ready_q;                   // rready/bready: high every cycle out of reset

    logic r_inst, r_data, b_done;
    logic data_rd_elig, inst_rd_elig;
    logic data_rd_acc, inst_rd_acc, data_wr_acc;
    logic ar_hs;

    always_comb begin
        r_inst       = rvalid && ready_q && (rid == INST_ID);
        r_data       = rvalid && ready_q && (rid == DATA_ID);
        b_done       = (w_state_q == W_RESP) && bvalid && ready_q;
        // Data read must not overtake a pending write to the same memory.
        data_rd_elig = data_sram_req && !data_sram_wr && !data_out_q && (w_state_q == W_IDLE);
        inst_rd_elig = inst_sram_req && !inst_out_q;
        data_rd_acc  = resetn && (ar_state_q == AR_IDLE) && data_rd_elig;
        inst_rd_acc  = resetn && (ar_state_q == AR_IDLE) && inst_rd_elig && !data_rd_elig;
        // Write must not overtake a data read still in the AR phase or in flight.
        data_wr_acc  = resetn && (w_state_q == W_IDLE) && data_sram_req && data_sram_wr &&
                       !data_out_q && !((ar_state_q == AR_SEND) && ar_data_q);
        ar_hs        = (ar_state_q == AR_SEND) && arready;

        ar_state_d = ar_state_q;
        ar_data_d  = ar_data_q;
        araddr_d   = araddr_q;
        arsize_d   = arsize_q;
        inst_out_d = inst_out_q;
        data_out_d = data_out_q;
        if (r_inst) inst_out_d = 1'b0;
        if (r_data) data_out_d = 1'b0;

        case (ar_state_q)
            AR_IDLE: begin
                if (data_rd_acc) begin
                    ar_state_d = AR_SEND;
                    ar_data_d  = 1'b1;
                    araddr_d   = data_sram_addr;
                    arsize_d   = data_sram_size;
                end else if (inst_rd_acc) begin
                    ar_state_d = AR_SEND;
                    ar_data_d  = 1'b0;
                    araddr_d   = inst_sram_addr;
                    arsize_d   = inst_sram_size;
                end
            end
            default: begin
                if (ar_hs) begin
                    ar_state_d = AR_IDLE;
                    if (ar_data_q) data_out_d = 1'b1;
                    else           inst_out_d = 1'b1;
                end
            end
        endcase

        w_state_d = w_state_q;
        awvalid_d = awvalid_q;
        wvalid_d  = wvalid_q;
        awaddr_d  = awaddr_q;
        awsize_d  = awsize_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        case (w_state_q)
            W_IDLE: begin
                if (data_wr_acc) begin
                    w_state_d = W_SEND;
                    awvalid_d = 1'b1;
                    wvalid_d  = 1'b1;
                    awaddr_d  = data_sram_addr;
                    awsize_d  = data_sram_size;
                    wdata_d   = data_sram_wdata;
                    wstrb_d   = data_sram_wstrb;
                end
            end
            W_SEND: begin
                if (awready) awvalid_d = 1'b0;
                if (wready)  wvalid_d  = 1'b0;
                if ((!awvalid_q || awready) && (!wvalid_q || wready)) w_state_d = W_RESP;
            end
            default: begin
                if (b_done) w_state_d = W_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            ar_state_q <= AR_IDLE;
            ar_data_q  <= 1'b0;
            araddr_q   <= '0;
            arsize_q   <= '0;
            inst_out_q <= 1'b0;
            data_out_q <= 1'b0;
            w_state_q  <= W_IDLE;
            awvalid_q  <= 1'b0;
            wvalid_q   <= 1'b0;
            awaddr_q   <= '0;
            awsize_q   <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            ready_q    <= 1'b0;
        end else begin
            ar_state_q <= ar_state_d;
            ar_data_q  <= ar_data_d;
            araddr_q   <= araddr_d;
            arsize_q   <= arsize_d;
            inst_out_q <= inst_out_d;
            data_out_q <= data_out_d;
            w_state_q  <= w_state_d;
            awvalid_q  <= awvalid_d;
            wvalid_q   <= wvalid_d;
            awaddr_q   <= awaddr_d;
            awsize_q   <= awsize_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
            ready_q    <= 1'b1;
        end
    end

    assign inst_sram_addr_ok = inst_rd_acc;
    assign data_sram_addr_ok = data_rd_acc || data_wr_acc;
    assign inst_sram_data_ok = r_inst;
    assign data_sram_data_ok = r_data || b_done;
    assign inst_sram_rdata   = rdata;
    assign data_sram_rdata   = rdata;

    assign arid    = ar_data_q ? DATA_ID : INST_ID;
    assign araddr  = araddr_q;
    assign arlen   = 8'd0;
    assign arsize  = {1'b0, arsize_q};
    assign arburst = 2'd1;
    assign arlock  = 2'd0;
    assign arcache = 4'd0;
    assign arprot  = 3'd0;
    assign arvalid = (ar_state_q == AR_SEND);
    assign rready  = ready_q;

    assign awid    = DATA_ID;
    assign awaddr  = awaddr_q;
    assign awlen   = 8'd0;
    assign awsize  = {1'b0, awsize_q};
    assign awburst = 2'd1;
    assign awlock  = 2'd0;
    assign awcache = 4'd0;
    assign awprot  = 3'd0;
    assign awvalid = awvalid_q;
    assign wid     = DATA_ID;
    assign wdata   = wdata_q;
    assign wstrb   = wstrb_q;
    assign wlast   = 1'b1;
    assign wvalid  = wvalid_q;
    assign bready  = ready_q;

    // Unused inputs: inst port is read-only; response codes, rlast and bid carry no information here.
    logic unused_ok;
    assign unused_ok = ^{inst_sram_wr, inst_sram_wstrb, inst_sram_wdata, rresp, rlast, bid, bresp};

endmodule

// File: tb/tb_sram_axi_bridge.sv
// tb/tb_sram_axi_bridge.sv - directed self-checking bench for sram_axi_bridge

module tb_sram_axi_bridge;
    localparam int ID_W = 4;

    logic clk = 1'b0;
    logic resetn;
    logic inst_sram_req, inst_sram_wr;
    logic [1:0] inst_sram_size;
    logic [3:0] inst_sram_wstrb;
    logic [31:0] inst_sram_addr, inst_sram_wdata;
    logic inst_sram_addr_ok, inst_sram_data_ok;
    logic [31:0] inst_sram_rdata;
    logic data_sram_req, data_sram_wr;
    logic [1:0] data_sram_size;
    logic [3:0] data_sram_wstrb;
    logic [31:0] data_sram_addr, data_sram_wdata;
    logic data_sram_addr_ok, data_sram_data_ok;
    logic [31:0] data_sram_rdata;
    logic [ID_W-1:0] arid, rid, awid, wid, bid;
    logic [31:0] araddr, rdata, awaddr, wdata;
    logic [7:0] arlen, awlen;
    logic [2:0] arsize, arprot, awsize, awprot;
    logic [1:0] arburst, arlock, awburst, awlock, rresp, bresp;
    logic [3:0] arcache, awcache, wstrb;
    logic arvalid, arready, rlast, rvalid, rready;
    logic awvalid, awready, wlast, wvalid, wready, bvalid, bready;

    int checks = 0;
    int errors = 0;

    sram_axi_bridge #(.ID_W(ID_W)) dut (
        .clk(clk), .resetn(resetn),
        .inst_sram_req(inst_sram_req), .inst_sram_wr(inst_sram_wr), .inst_sram_size(inst_sram_size),
        .inst_sram_wstrb(inst_sram_wstrb), .inst_sram_addr(inst_sram_addr), .inst_sram_wdata(inst_sram_wdata),
        .inst_sram_addr_ok(inst_sram_addr_ok), .inst_sram_data_ok(inst_sram_data_ok), .inst_sram_rdata(inst_sram_rdata),
        .data_sram_req(data_sram_req), .data_sram_wr(data_sram_wr), .data_sram_size(data_sram_size),
        .data_sram_wstrb(data_sram_wstrb), .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata),
        .data_sram_addr_ok(data_sram_addr_ok), .data_sram_data_ok(data_sram_data_ok), .data_sram_rdata(data_sram_rdata),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst), .arlock(arlock),
        .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst), .awlock(awlock),
        .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
        .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        resetn = 1'b0;
        inst_sram_req = 0; inst_sram_wr = 0; inst_sram_size = 0; inst_sram_wstrb = 0;
        inst_sram_addr = 0; inst_sram_wdata = 0;
        data_sram_req = 0; data_sram_wr = 0; data_sram_size = 0; data_sram_wstrb = 0;
        data_sram_addr = 0; data_sram_wdata = 0;
        arready = 0; rid = 0; rdata = 0; rresp = 0; rlast = 1; rvalid = 0;
        awready = 0; wready = 0; bid = 0; bresp = 0; bvalid = 0;

        // Reset state and constant fields
        step(); step(); smp();
        chk("rst_arvalid", arvalid, 0);
        chk("rst_awvalid", awvalid, 0);
        chk("rst_wvalid", wvalid, 0);
        chk("rst_rready", rready, 0);
        chk("rst_bready", bready, 0);
        chk("const_arlen", arlen, 0);
        chk("const_arburst", arburst, 1);
        chk("const_awid", awid, 1);
        chk("const_wid", wid, 1);
        chk("const_wlast", wlast, 1);
        step(); resetn = 1'b1;
        step(); smp();
        chk("rready_on", rready, 1);
        chk("bready_on", bready, 1);

        // 1: inst read, arready immediate, rvalid one cycle later
        step(); inst_sram_req = 1; inst_sram_addr = 32'h1C000000; inst_sram_size = 2;
        smp();
        chk("t1_inst_addr_ok", inst_sram_addr_ok, 1);
        chk("t1_data_addr_ok", data_sram_addr_ok, 0);
        step(); inst_sram_req = 0; arready = 1;
        smp();
        chk("t1_arvalid", arvalid, 1);
        chk("t1_arid", arid, 0);
        chk("t1_araddr", araddr, 32'h1C000000);
        chk("t1_arsize", arsize, 3'b010);
        step(); arready = 0; rvalid = 1; rid = 0; rdata = 32'h12345678;
        smp();
        chk("t1_arvalid_drop", arvalid, 0);
        chk("t1_inst_data_ok", inst_sram_data_ok, 1);
        chk("t1_inst_rdata", inst_sram_rdata, 32'h12345678);
        chk("t1_data_data_ok", data_sram_data_ok, 0);
        step(); rvalid = 0;
        smp();
        chk("t1_data_ok_off", inst_sram_data_ok, 0);

        // 2: simultaneous inst and data reads, data wins
        step(); inst_sram_req = 1; inst_sram_addr = 32'h1C000040; inst_sram_size = 2;
        data_sram_req = 1; data_sram_wr = 0; data_sram_addr = 32'h00001230; data_sram_size = 2;
        smp();
        chk("t2_data_addr_ok", data_sram_addr_ok, 1);
        chk("t2_inst_addr_ok", inst_sram_addr_ok, 0);
        step(); data_sram_req = 0;
        smp();
        chk("t2_arvalid", arvalid, 1);
        chk("t2_arid", arid, 1);
        chk("t2_araddr", araddr, 32'h00001230);
        chk("t2_inst_wait0", inst_sram_addr_ok, 0);
        step(); arready = 1;
        smp();
        chk("t2_inst_wait1", inst_sram_addr_ok, 0);
        step(); arready = 0;
        smp();
        chk("t2_inst_addr_ok", inst_sram_addr_ok, 1);
        step(); inst_sram_req = 0; arready = 1;
        smp();
        chk("t2_arid_inst", arid, 0);
        chk("t2_araddr_inst", araddr, 32'h1C000040);

        // 5: out-of-order return, rid 1 then rid 0
        step(); arready = 0; rvalid = 1; rid = 1; rdata = 32'hD0D0D0D0;
        smp();
        chk("t5_data_ok", data_sram_data_ok, 1);
        chk("t5_data_rdata", data_sram_rdata, 32'hD0D0D0D0);
        chk("t5_inst_ok_quiet", inst_sram_data_ok, 0);
        step(); rid = 0; rdata = 32'h11110000;
        smp();
        chk("t5_inst_ok", inst_sram_data_ok, 1);
        chk("t5_inst_rdata", inst_sram_rdata, 32'h11110000);
        chk("t5_data_ok_quiet", data_sram_data_ok, 0);
        step(); rvalid = 0;

        // 3: data write, awready delayed 3 cycles, wready immediate
        data_sram_req = 1; data_sram_wr = 1; data_sram_addr = 32'h00000800;
        data_sram_size = 1; data_sram_wstrb = 4'b0011; data_sram_wdata = 32'h0000BEEF;
        smp();
        chk("t3_addr_ok", data_sram_addr_ok, 1);
        step(); data_sram_req = 0; data_sram_wr = 0; wready = 1;
        smp();
        chk("t3_awvalid1", awvalid, 1);
        chk("t3_wvalid1", wvalid, 1);
        chk("t3_awaddr", awaddr, 32'h00000800);
        chk("t3_awsize", awsize, 3'b001);
        chk("t3_wstrb", wstrb, 4'b0011);
        chk("t3_wdata", wdata, 32'h0000BEEF);
        step(); wready = 0;
        smp();
        chk("t3_wvalid_drop", wvalid, 0);
        chk("t3_awvalid2", awvalid, 1);
        step();
        smp();
        chk("t3_awvalid3", awvalid, 1);
        chk("t3_awaddr_stable", awaddr, 32'h00000800);
        step(); awready = 1;
        smp();
        chk("t3_awvalid4", awvalid, 1);
        chk("t3_no_early_ok", data_sram_data_ok, 0);

        // 4: data read while write in W_RESP
        step(); awready = 0;
        data_sram_req = 1; data_sram_wr = 0; data_sram_addr = 32'h00000900; data_sram_size = 2;
        smp();
        chk("t3_awvalid_drop", awvalid, 0);
        chk("t4_blocked0", data_sram_addr_ok, 0);
        step(); bvalid = 1;
        smp();
        chk("t3_b_data_ok", data_sram_data_ok, 1);
        chk("t4_blocked1", data_sram_addr_ok, 0);
        step(); bvalid = 0;
        smp();
        chk("t4_accept", data_sram_addr_ok, 1);
        chk("t4_b_ok_off", data_sram_data_ok, 0);
        step(); data_sram_req = 0; arready = 1;
        smp();
        chk("t4_arid", arid, 1);
        step(); arready = 0; rvalid = 1; rid = 1; rdata = 32'hCAFEF00D;
        smp();
        chk("t4_rdata", data_sram_rdata, 32'hCAFEF00D);
        step(); rvalid = 0;

        // 6: reset with awvalid and arvalid high
        inst_sram_req = 1; inst_sram_addr = 32'h1C000080;
        data_sram_req = 1; data_sram_wr = 1; data_sram_addr = 32'h00000A00;
        data_sram_wstrb = 4'hF; data_sram_wdata = 32'h55AA55AA; data_sram_size = 2;
        smp();
        chk("t6_inst_addr_ok", inst_sram_addr_ok, 1);
        chk("t6_data_addr_ok", data_sram_addr_ok, 1);
        step(); inst_sram_req = 0; data_sram_req = 0;
        smp();
        chk("t6_arvalid_pre", arvalid, 1);
        chk("t6_awvalid_pre", awvalid, 1);
        step(); resetn = 0; inst_sram_req = 1; data_sram_req = 1;
        step();
        smp();
        chk("t6_arvalid", arvalid, 0);
        chk("t6_awvalid", awvalid, 0);
        chk("t6_wvalid", wvalid, 0);
        chk("t6_inst_addr_ok", inst_sram_addr_ok, 0);
        chk("t6_data_addr_ok", data_sram_addr_ok, 0);
        chk("t6_data_ok", data_sram_data_ok, 0);
        chk("t6_rready", rready, 0);
        step(); resetn = 1;
        smp();
        chk("t6_inst_idle", inst_sram_addr_ok, 1);
        chk("t6_data_w_idle", data_sram_addr_ok, 1);
        step(); inst_sram_req = 0; data_sram_req = 0;
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sram_axi_bridge.md
Name: sram_axi_bridge

Overview:
Converts the core's two sram-like ports (inst, data) into a single AXI3 master. It sits directly downstream of cpu_core inside the CPU top, where the core's sram-like outputs and the SoC AXI bus meet.
Supports up to two outstanding reads (one per port, distinguished by ID) and one outstanding write.

Parameters:
ID_W, 4, width of arid/rid/awid/bid; inst uses ID 0, data uses ID 1.

Ports:
clk  in  1  clock, all logic on rising edge
resetn  in  1  synchronous, active-low reset
{inst,data}_sram_req  in  1  request valid
{inst,data}_sram_wr  in  1  1=write; ignored on inst port (inst port is read-only)
{inst,data}_sram_size  in  2  0/1/2 = byte/half/word
{inst,data}_sram_wstrb  in  4  write byte enables
{inst,data}_sram_addr  in  32  byte address
{inst,data}_sram_wdata  in  32  write data
{inst,data}_sram_addr_ok  out  1  request accepted this cycle
{inst,data}_sram_data_ok  out  1  read data valid / write complete
{inst,data}_sram_rdata  out  32  read data
arid  out  ID_W;  araddr  out  32;  arsize  out  3;  arvalid  out  1;  arready  in  1
rid  in  ID_W;  rdata  in  32;  rresp  in  2 (ignored);  rlast  in  1 (ignored);  rvalid  in  1;  rready  out  1
awid  out  ID_W (=1);  awaddr  out  32;  awsize  out  3;  awvalid  out  1;  awready  in  1
wid  out  ID_W (=1);  wdata  out  32;  wstrb  out  4;  wlast  out  1 (=1);  wvalid  out  1;  wready  in  1
bid  in  ID_W (ignored);  bresp  in  2 (ignored);  bvalid  in  1;  bready  out  1
arlen/awlen  out  8  constant 0;  arburst/awburst  out  2  constant 1;  arlock/awlock, arcache/awcache, arprot/awprot  out  constant 0

Behaviour:
- Reset (resetn=0 at edge): both FSMs return to IDLE; arvalid, awvalid, wvalid, addr_ok, data_ok = 0; rready = bready = 0; outstanding flags cleared. Reset mid-transaction abandons in-flight AXI transactions; the slave must be reset together with the bridge.
- rready and bready are 1 in every cycle out of reset, so responses are never back-pressured.
- Read FSM AR_IDLE -> AR_SEND:
  - In AR_IDLE, at most one read is accepted per cycle.
  - A data read (data_sram_req && data_sram_wr=0) is eligible when no data read is outstanding and the write FSM is in W_IDLE (read-after-write ordering).
  - An inst read is eligible when no inst read is outstanding.
  - Data has priority over inst when both are eligible.
  - The winner gets addr_ok=1 combinationally in the same cycle; araddr, arsize = {0, size} and arid are registered, and the FSM moves to AR_SEND.
  - AR_SEND holds arvalid=1 and stable fields until arready, then sets that port's outstanding flag and returns to AR_IDLE. AR_SEND never accepts a new request.
- Read return:
  - rvalid && rid==0 gives inst_sram_data_ok=1 and inst_sram_rdata=rdata, combinationally, and clears the inst outstanding flag.
  - rvalid && rid==1 does the same on the data port and clears the data outstanding flag.
  - Out-of-order return between IDs is legal.
- Write FSM W_IDLE -> W_SEND -> W_RESP:
  - In W_IDLE, data_sram_req && data_sram_wr is accepted (addr_ok=1) when no data read is outstanding and the read FSM is not in AR_SEND carrying the data port.
  - On acceptance, register awaddr, awsize, wdata and wstrb, and set awvalid = wvalid = 1.
  - In W_SEND, awvalid and wvalid each drop independently on their own handshake. When both handshakes are done, move to W_RESP.
  - In W_RESP, bvalid gives data_sram_data_ok=1 and the FSM returns to W_IDLE.
- A single data-port request is either a read or a write, never both, so data_ok from R and from B can never coincide.
- Latency:
  - Read: request accepted at T; arvalid at T+1; with arready at T+1 and rvalid at T+2, data_ok is at T+2.
  - Write: with both readies immediate, data_ok is at the bvalid cycle, earliest T+2.
- Addresses pass through unmodified. wstrb is taken verbatim from the sram port.

Test Plan:
1. Inst read 0x1C000000, size 2; arready on first arvalid cycle; rid 0, rdata 0x12345678 one cycle later -> arid 0, arsize 3'b010, inst_sram_data_ok=1 with 0x12345678 two cycles after addr_ok.
2. Inst and data reads requested in the same cycle -> data_addr_ok first with arid 1; inst_addr_ok in the first AR_IDLE cycle after the AR handshake.
3. Data write 0x800, size 1, wstrb 0011, wdata 0xBEEF; awready delayed 3 cycles, wready immediate -> wvalid lasts 1 cycle; awvalid held 4 cycles with fields stable; data_ok in the bvalid cycle.
4. Data read issued while the write FSM is in W_RESP -> data_addr_ok stays 0 until the cycle after bvalid.
5. Inst (ID 0) and data (ID 1) reads outstanding; slave returns rid 1 then rid 0 -> each rdata appears only on its own port, with data_ok one cycle each.
6. resetn=0 while awvalid=1 and arvalid=1 -> at the next edge all valids, addr_ok and data_ok are 0, and both FSMs are IDLE.
